spi_xfer_scheduler: RTL and testbench
=====================================

SPI_XFER_SCHEDULER -- requirements
Module: spi_xfer_scheduler

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing one slaveselect instance.
REQ-002 Parameter: START_TMO, 8, PCLK cycles allowed between send_data pulse and tip rising.
REQ-003 Port: PCLK  input  1  the single clock; all logic rising-edge.
REQ-004 Port: PRESETn  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  NREQ  per-requester transfer request (level).
REQ-006 Port: req_mode  input  2*NREQ  per-requester spi_mode; requester i at bits [2i+1:2i].
REQ-007 Port: req_baud  input  16*NREQ  per-requester BaudRateDivisor; requester i at bits [16i+15:16i].
REQ-008 Port: hold  input  1  when 1, no new transfer starts; a transfer in flight completes.
REQ-009 Port: mstr  output  1  to slaveselect; master enable.
REQ-010 Port: spiswai  output  1  to slaveselect; SPI wait-mode request.
REQ-011 Port: spi_mode  output  2  to slaveselect; mode of the granted requester.
REQ-012 Port: BaudRateDivisor  output  16  to slaveselect; divisor of the granted requester.
REQ-013 Port: send_data  output  1  to slaveselect; one-cycle start pulse.
REQ-014 Port: tip  input  1  from slaveselect; transfer in progress.
REQ-015 Port: gnt  output  NREQ  one-hot grant, held from LOAD through DONE.
REQ-016 Port: done  output  NREQ  one-cycle completion pulse on granted bit.
REQ-017 Port: err  output  NREQ  one-cycle start-timeout pulse on granted bit.
REQ-018 Port: busy  output  1  1 in every state except IDLE.

Function
REQ-019 FSM states IDLE, LOAD, START, WAIT_TIP, XFER, DONE; one state per cycle except WAIT_TIP and XFER.
REQ-020 IDLE -> LOAD when hold=0 and req!=0; winner chosen round-robin, search starting at last_gnt+1 modulo NREQ.
REQ-021 LOAD: gnt, spi_mode, BaudRateDivisor registered from winner; mstr=1; no send_data (one settle cycle).
REQ-022 START: send_data=1 for exactly this cycle; next WAIT_TIP with timeout counter cleared.
REQ-023 WAIT_TIP: tip=1 -> XFER; counter reaches START_TMO-1 with tip=0 -> err pulse on granted bit, then DONE-path without done pulse.
REQ-024 XFER: stays while tip=1; tip=0 -> DONE.
REQ-025 DONE: done pulse on granted bit (unless timeout), last_gnt updated to granted index, gnt cleared at exit, next IDLE.
REQ-026 Minimum request-to-send_data latency: 2 cycles (LOAD, START) after IDLE sampling.
REQ-027 spi_mode/BaudRateDivisor hold their values from LOAD until the next LOAD; requester input changes mid-transfer ignored.
REQ-028 req deassert after grant: transfer still completes and done still pulses.
REQ-029 Same requester still requesting in DONE: not re-granted before other pending requesters (fairness).
REQ-030 hold=1 in IDLE: spiswai=1, no grant; hold=1 elsewhere: spiswai=0 until return to IDLE.
REQ-031 mstr=1 whenever busy=1 or req!=0; else 0.
REQ-032 done and err never both 1; at most one bit of gnt/done/err set.

Reset
REQ-033 PRESETn=0 asynchronously forces IDLE, gnt=0, done=0, err=0, send_data=0, mstr=0, spiswai=0, spi_mode=2'b00, BaudRateDivisor=0, busy=0, last_gnt=NREQ-1 (first search starts at 0).
REQ-034 Reset mid-transfer aborts without done or err; no pulse after release until a new arbitration.

Structure
REQ-035 Package spi_sched_pkg holds the state enum, default NREQ, START_TMO.
REQ-036 One sub-module spi_rr_arbiter: combinational round-robin winner from req and last_gnt, outputs one-hot and index.

Verification
REQ-037 req=4'b0001, mode 2'b00, baud 10, tip rises 2 cycles after send_data, held 20 -> send_data 2 cycles after request, done[0] pulse 1 cycle after tip falls.
REQ-038 req=4'b1111 held continuously -> grant order 0,1,2,3,0 with one done per grant.
REQ-039 tip never rises, START_TMO=8 -> err[0] pulse 8 cycles after send_data, no done, busy drops.
REQ-040 hold=1 with req=4'b0010 -> spiswai=1, no send_data; hold=0 -> gnt=4'b0010 next cycle.
REQ-041 PRESETn low during XFER -> all outputs at reset values immediately, no done after release.
REQ-042 req_baud[15:0] changed from 10 to 3 during XFER -> BaudRateDivisor stays 10 until next LOAD.

Source files
------------

// File: rtl/spi_sched_pkg.sv
// -----------------------------------------------------------------------------
// spi_sched_pkg
// Shared definitions for the SPI transfer scheduler:
//   - default requester count and start-timeout length
//   - scheduler FSM state encoding
//   - helper that sizes an index for a given number of requesters
// -----------------------------------------------------------------------------
package spi_sched_pkg;

    localparam int NREQ_DEFAULT      = 4;
    localparam int START_TMO_DEFAULT = 8;

    // Explicit encodings keep the state register readable in waveforms and
    // stable if a state is ever appended.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_START    = 3'd2,
        ST_WAIT_TIP = 3'd3,
        ST_XFER     = 3'd4,
        ST_DONE     = 3'd5
    } sched_state_t;

    // Width of a requester index; never zero so a single requester still
    // gets a legal one-bit vector.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// spi_rr_arbiter
// Combinational round-robin winner selection. The search begins at the
// requester after the last one granted and wraps modulo NREQ, so the most
// recently served requester is considered last.
//
// Ports:
//   i_req         [NREQ-1:0]  pending requests
//   i_last_gnt    [IDXW-1:0]  index of the previously granted requester
//   o_gnt_onehot  [NREQ-1:0]  one-hot winner (all zero when no request)
//   o_gnt_idx     [IDXW-1:0]  binary index of the winner
//   o_valid                   1 when some requester is pending
// -----------------------------------------------------------------------------
module spi_rr_arbiter
    import spi_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDXW = idxWidth(NREQ_DEFAULT)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_last_gnt,
    output logic [NREQ-1:0] o_gnt_onehot,
    output logic [IDXW-1:0] o_gnt_idx,
    output logic            o_valid
);

    logic w_found;

    // Walk the NREQ candidates in priority order; the first pending one wins.
    always_comb begin
        w_found      = 1'b0;
        o_gnt_onehot = '0;
        o_gnt_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && i_req[(int'(i_last_gnt) + k) % NREQ]) begin
                w_found                                         = 1'b1;
                o_gnt_onehot[(int'(i_last_gnt) + k) % NREQ]     = 1'b1;
                o_gnt_idx = IDXW'((int'(i_last_gnt) + k) % NREQ);
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/spi_xfer_scheduler.sv
// -----------------------------------------------------------------------------
// spi_xfer_scheduler
// Shares one SPI slave-select engine between NREQ requesters. A round-robin
// winner is latched, its mode/divisor are presented to the engine, a one-cycle
// send_data pulse starts the transfer, and the scheduler then tracks tip until
// the transfer ends (done pulse) or never starts (err pulse after START_TMO).
//
// Ports:
//   PCLK, PRESETn                 clock, async active-low reset
//   req[NREQ]                     per-requester transfer request (level)
//   req_mode[2*NREQ]              per-requester SPI mode
//   req_baud[16*NREQ]             per-requester baud divisor
//   hold                          blocks new transfers while 1
//   mstr, spiswai, spi_mode,
//   BaudRateDivisor, send_data    controls towards the slave-select engine
//   tip                           transfer-in-progress from the engine
//   gnt[NREQ]                     one-hot grant, LOAD through DONE
//   done[NREQ], err[NREQ]         one-cycle completion / start-timeout pulses
//   busy                          1 whenever the FSM is not idle
// -----------------------------------------------------------------------------
module spi_xfer_scheduler
    import spi_sched_pkg::*;
#(
    parameter int NREQ      = NREQ_DEFAULT,
    parameter int START_TMO = START_TMO_DEFAULT
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    req_mode,
    input  logic [16*NREQ-1:0]   req_baud,
    input  logic                 hold,
    output logic                 mstr,
    output logic                 spiswai,
    output logic [1:0]           spi_mode,
    output logic [15:0]          BaudRateDivisor,
    output logic                 send_data,
    input  logic                 tip,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic                 busy
);

    localparam int IDXW = idxWidth(NREQ);
    localparam int CNTW = $clog2(START_TMO + 1);
    localparam logic [CNTW-1:0] TMO_LAST = CNTW'(START_TMO - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREQ - 1);

    sched_state_t    r_state;
    sched_state_t    w_next;
    logic [NREQ-1:0] r_gnt;
    logic [IDXW-1:0] r_gnt_idx;
    logic [IDXW-1:0] r_last_gnt;
    logic [1:0]      r_mode;
    logic [15:0]     r_baud;
    logic [CNTW-1:0] r_cnt;
    logic            r_tmo;

    logic [NREQ-1:0] w_win_onehot;
    logic [IDXW-1:0] w_win_idx;
    logic            w_win_valid;
    logic            w_launch;
    logic            w_tmo_hit;

    spi_rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_arb (
        .i_req        (req),
        .i_last_gnt   (r_last_gnt),
        .o_gnt_onehot (w_win_onehot),
        .o_gnt_idx    (w_win_idx),
        .o_valid      (w_win_valid)
    );

    assign w_launch  = (r_state == ST_IDLE) && !hold && w_win_valid;
    // Timeout fires in the last allowed WAIT_TIP cycle so err lands exactly
    // START_TMO cycles after the send_data pulse.
    assign w_tmo_hit = (r_state == ST_WAIT_TIP) && !tip && (r_cnt == TMO_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_launch) w_next = ST_LOAD;
            ST_LOAD:     w_next = ST_START;
            ST_START:    w_next = ST_WAIT_TIP;
            ST_WAIT_TIP: begin
                if (tip)            w_next = ST_XFER;
                else if (w_tmo_hit) w_next = ST_DONE;
            end
            ST_XFER:     if (!tip) w_next = ST_DONE;
            ST_DONE:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // The winner's configuration is captured once at launch so requester
    // inputs may change freely while the transfer is in flight.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_last_gnt <= IDX_LAST;
            r_mode     <= 2'b00;
            r_baud     <= 16'd0;
            r_cnt      <= '0;
            r_tmo      <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_gnt     <= w_win_onehot;
                        r_gnt_idx <= w_win_idx;
                        r_mode    <= req_mode[int'(w_win_idx)*2 +: 2];
                        r_baud    <= req_baud[int'(w_win_idx)*16 +: 16];
                        r_tmo     <= 1'b0;
                    end
                end
                ST_START: r_cnt <= '0;
                ST_WAIT_TIP: begin
                    if (w_tmo_hit)
                        r_tmo <= 1'b1;
                    else if (!tip)
                        r_cnt <= r_cnt + 1'b1;
                end
                ST_DONE: begin
                    r_last_gnt <= r_gnt_idx;
                    r_gnt      <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy            = (r_state != ST_IDLE);
    assign gnt             = r_gnt;
    assign spi_mode        = r_mode;
    assign BaudRateDivisor = r_baud;
    assign send_data       = (r_state == ST_START);
    assign done            = ((r_state == ST_DONE) && !r_tmo) ? r_gnt : '0;
    assign err             = w_tmo_hit ? r_gnt : '0;

    // These two outputs are combinational on live inputs; qualifying them
    // with PRESETn keeps them at 0 while reset is asserted.
    assign mstr    = PRESETn && (busy || (req != '0));
    assign spiswai = PRESETn && (r_state == ST_IDLE) && hold;

endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_spi_xfer_scheduler
// Directed bench for spi_xfer_scheduler. Stimulus pushes expected send_data,
// done and err events (with the cycle they must appear in) into a queue; a
// negedge monitor pops and compares every event the DUT presents.
// -----------------------------------------------------------------------------
module tb_spi_xfer_scheduler;

    localparam int KSEND = 0;
    localparam int KDONE = 1;
    localparam int KERR  = 2;

    typedef struct {
        int         kind;
        logic [3:0] val;
        int         cyc;
    } exp_t;

    logic        PCLK;
    logic        PRESETn;
    logic [3:0]  req;
    logic [7:0]  req_mode;
    logic [63:0] req_baud;
    logic        hold;
    logic        tip;
    logic        mstr;
    logic        spiswai;
    logic [1:0]  spi_mode;
    logic [15:0] BaudRateDivisor;
    logic        send_data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  err;
    logic        busy;

    int   cyc;
    int   vectors;
    int   miscompares;
    exp_t expQ[$];

    spi_xfer_scheduler #(
        .NREQ      (4),
        .START_TMO (8)
    ) dut (
        .PCLK            (PCLK),
        .PRESETn         (PRESETn),
        .req             (req),
        .req_mode        (req_mode),
        .req_baud        (req_baud),
        .hold            (hold),
        .mstr            (mstr),
        .spiswai         (spiswai),
        .spi_mode        (spi_mode),
        .BaudRateDivisor (BaudRateDivisor),
        .send_data       (send_data),
        .tip             (tip),
        .gnt             (gnt),
        .done            (done),
        .err             (err),
        .busy            (busy)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic pushExp(input int kind, input logic [3:0] val, input int at);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = at;
        expQ.push_back(e);
    endtask

    // Runs one transfer starting in an IDLE cycle where the request is
    // already visible: tip rises d cycles after send_data and stays len cycles.
    task automatic applyStimulus(input int d, input int len, input logic [3:0] expGnt,
                                 input logic [15:0] expBaud, input logic holdMid);
        int s;
        s = cyc;
        pushExp(KSEND, expGnt, s + 2);
        pushExp(KDONE, expGnt, s + 3 + d + len);
        waitCycles(1);
        checkOutput("gnt in LOAD", 32'(gnt), 32'(expGnt));
        checkOutput("baud in LOAD", 32'(BaudRateDivisor), 32'(expBaud));
        if (holdMid) hold = 1'b1;
        waitCycles(1);
        checkOutput("spiswai while busy", 32'(spiswai), 32'(0));
        waitCycles(d);
        tip = 1'b1;
        waitCycles(len);
        tip = 1'b0;
        waitCycles(2);
        checkOutput("gnt after DONE", 32'(gnt), 32'(0));
    endtask

    // Monitor: every send_data / done / err occurrence must match the head
    // of the expected-event queue, including the cycle it appears in.
    always @(negedge PCLK) begin
        if (PRESETn && (send_data || (done != 4'b0) || (err != 4'b0))) begin
            int         kind;
            logic [3:0] val;
            exp_t       e;
            if (send_data) begin
                kind = KSEND;
                val  = gnt;
            end else if (done != 4'b0) begin
                kind = KDONE;
                val  = done;
            end else begin
                kind = KERR;
                val  = err;
            end
            checkOutput("done/err exclusive", 32'(done & {4{err != 4'b0}}), 32'(0));
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected event: kind %0d bits %0d at cycle %0d, expected none",
                         kind, val, cyc);
            end else begin
                e = expQ.pop_front();
                checkOutput("event kind", 32'(kind), 32'(e.kind));
                checkOutput("event bits", 32'(val), 32'(e.val));
                checkOutput("event cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int s;
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        PRESETn     = 1'b0;
        req         = 4'b1111;
        hold        = 1'b1;
        tip         = 1'b0;
        req_mode    = 8'd0;
        req_baud    = 64'd0;

        // Reset values, with req/hold active to prove mstr/spiswai stay low.
        #2;
        checkOutput("reset mstr", 32'(mstr), 32'(0));
        checkOutput("reset spiswai", 32'(spiswai), 32'(0));
        checkOutput("reset busy", 32'(busy), 32'(0));
        checkOutput("reset gnt", 32'(gnt), 32'(0));
        checkOutput("reset send_data", 32'(send_data), 32'(0));
        checkOutput("reset baud", 32'(BaudRateDivisor), 32'(0));
        waitCycles(2);
        req     = 4'b0000;
        hold    = 1'b0;
        PRESETn = 1'b1;
        waitCycles(2);

        // Single requester 0, baud 10; req dropped after grant, config
        // changed mid-transfer must not reach the outputs.
        req      = 4'b0001;
        req_mode = 8'b0000_0000;
        req_baud = {16'd0, 16'd0, 16'd0, 16'd10};
        s        = cyc;
        pushExp(KSEND, 4'b0001, s + 2);
        pushExp(KDONE, 4'b0001, s + 25);
        waitCycles(1);
        checkOutput("t1 gnt", 32'(gnt), 32'(4'b0001));
        checkOutput("t1 baud", 32'(BaudRateDivisor), 32'(10));
        checkOutput("t1 busy", 32'(busy), 32'(1));
        waitCycles(1);
        req = 4'b0000;
        waitCycles(2);
        tip = 1'b1;
        waitCycles(6);
        req_baud[15:0] = 16'd3;
        req_mode[1:0]  = 2'b11;
        waitCycles(2);
        checkOutput("t1 baud held", 32'(BaudRateDivisor), 32'(10));
        checkOutput("t1 mode held", 32'(spi_mode), 32'(0));
        checkOutput("t1 mstr busy no req", 32'(mstr), 32'(1));
        waitCycles(12);
        tip = 1'b0;
        waitCycles(2);
        checkOutput("t1 busy after", 32'(busy), 32'(0));
        checkOutput("t1 mstr idle", 32'(mstr), 32'(0));

        // Fresh reset, all four requesting: grant order 0,1,2,3,0.
        PRESETn = 1'b0;
        waitCycles(1);
        PRESETn = 1'b1;
        waitCycles(1);
        req_mode = {2'd3, 2'd2, 2'd1, 2'd0};
        req_baud = {16'd103, 16'd102, 16'd101, 16'd100};
        req      = 4'b1111;
        applyStimulus(2, 3, 4'b0001, 16'd100, 1'b0);
        applyStimulus(2, 3, 4'b0010, 16'd101, 1'b0);
        applyStimulus(2, 3, 4'b0100, 16'd102, 1'b0);
        applyStimulus(2, 3, 4'b1000, 16'd103, 1'b0);
        applyStimulus(2, 3, 4'b0001, 16'd100, 1'b0);
        req = 4'b0000;

        // Start timeout: tip never rises, err 8 cycles after send_data.
        req = 4'b0001;
        s   = cyc;
        pushExp(KSEND, 4'b0001, s + 2);
        pushExp(KERR, 4'b0001, s + 10);
        waitCycles(2);
        req = 4'b0000;
        waitCycles(9);
        checkOutput("t3 busy in DONE", 32'(busy), 32'(1));
        waitCycles(1);
        checkOutput("t3 busy dropped", 32'(busy), 32'(0));

        // Hold in IDLE blocks the grant; release grants requester 1 next cycle.
        hold = 1'b1;
        req  = 4'b0010;
        waitCycles(3);
        checkOutput("t4 spiswai idle", 32'(spiswai), 32'(1));
        checkOutput("t4 gnt held off", 32'(gnt), 32'(0));
        checkOutput("t4 busy held off", 32'(busy), 32'(0));
        checkOutput("t4 mstr on req", 32'(mstr), 32'(1));
        hold = 1'b0;
        applyStimulus(1, 2, 4'b0010, 16'd101, 1'b1);
        checkOutput("t4 spiswai back idle", 32'(spiswai), 32'(1));
        checkOutput("t4 no regrant", 32'(busy), 32'(0));
        hold = 1'b0;
        req  = 4'b0000;
        waitCycles(1);

        // Reset asserted during XFER of requester 2.
        req = 4'b0100;
        s   = cyc;
        pushExp(KSEND, 4'b0100, s + 2);
        waitCycles(4);
        tip = 1'b1;
        waitCycles(4);
        checkOutput("t5 mode before", 32'(spi_mode), 32'(2));
        checkOutput("t5 baud before", 32'(BaudRateDivisor), 32'(102));
        PRESETn = 1'b0;
        #1;
        checkOutput("t5 busy", 32'(busy), 32'(0));
        checkOutput("t5 gnt", 32'(gnt), 32'(0));
        checkOutput("t5 mstr", 32'(mstr), 32'(0));
        checkOutput("t5 mode", 32'(spi_mode), 32'(0));
        checkOutput("t5 baud", 32'(BaudRateDivisor), 32'(0));
        checkOutput("t5 done", 32'(done), 32'(0));
        checkOutput("t5 err", 32'(err), 32'(0));
        req = 4'b0000;
        tip = 1'b0;
        waitCycles(2);
        PRESETn = 1'b1;
        waitCycles(20);
        checkOutput("t5 idle after", 32'(busy), 32'(0));

        checkOutput("pending events", 32'(expQ.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
